wb_byte_master: RTL and testbench

Byte-stream to Wishbone master bridge. Converts host command bytes (from the UART RX byte interface) into single Wishbone read/write cycles toward the glitch register slave. Returns status and read data as bytes to the UART TX interface. Sits between the UART and the glitch register block; one transaction in flight at a time.

---
 rtl/wb_byte_master_pkg.sv | 27 ++
 rtl/wb_ack_timer.sv | 27 ++
 rtl/wb_byte_master.sv | 136 +++++++++++++
 tb/tb_wb_byte_master.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_byte_master_pkg.sv
// rtl/wb_byte_master_pkg.sv - shared status codes, command fields and state encoding
package wb_byte_master_pkg;

    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_TIMEOUT = 8'h01;
    localparam logic [7:0] ST_BADCMD  = 8'h02;

    localparam int CMD_WE_BIT  = 7;
    localparam int CMD_RSV_MSB = 6;
    localparam int CMD_RSV_LSB = 4;
    localparam int CMD_ADR_MSB = 3;
    localparam int CMD_ADR_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_DATA,
        S_STROBE,
        S_WAIT_ACK,
        S_SEND_STATUS,
        S_SEND_DATA
    } state_t;

    function automatic logic cmd_is_bad(input logic [7:0] cmd);
        return cmd[CMD_RSV_MSB:CMD_RSV_LSB] != 3'b000;
    endfunction

endpackage

// File: rtl/wb_ack_timer.sv
// rtl/wb_ack_timer.sv - saturating wait counter flagging the last cycle of the ack window
module wb_ack_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != CNT_W'(TIMEOUT))) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_byte_master.sv
// rtl/wb_byte_master.sv - byte-stream to single-cycle Wishbone master bridge
module wb_byte_master
    import wb_byte_master_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [DATA_W-1:0] wb_dat_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    output logic              wb_we_o,
    output logic              wb_stb_o,
    input  logic              wb_ack_i,
    output logic              busy
);
    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_adr;
    logic [DATA_W-1:0]  r_wdat;
    logic               r_we;
    logic [7:0]         r_status;
    logic [7:0]         r_rdata;
    logic               w_tmr_clear;
    logic               w_tmr_en;
    logic               w_tmr_expired;
    logic               w_ack_ok;
    logic               w_expired_now;

    wb_ack_timer #(.TIMEOUT(TIMEOUT)) u_ack_timer (
        .i_clk     (clk_i),
        .i_rst_n   (rst_i),
        .i_clear   (w_tmr_clear),
        .i_enable  (w_tmr_en),
        .o_expired (w_tmr_expired)
    );

    // Acks are only meaningful while a cycle is outstanding; late acks fall through.
    assign w_ack_ok      = wb_ack_i && ((r_state == S_STROBE) || (r_state == S_WAIT_ACK));
    assign w_expired_now = (r_state == S_WAIT_ACK) && !wb_ack_i && w_tmr_expired;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        rx_ready    = 1'b0;
        tx_valid    = 1'b0;
        wb_stb_o    = 1'b0;
        w_tmr_clear = 1'b0;
        w_tmr_en    = 1'b0;
        case (r_state)
            S_IDLE: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if (cmd_is_bad(rx_data))        w_state_nxt = S_SEND_STATUS;
                    else if (rx_data[CMD_WE_BIT])   w_state_nxt = S_GET_DATA;
                    else                            w_state_nxt = S_STROBE;
                end
            end
            S_GET_DATA: begin
                rx_ready = 1'b1;
                if (rx_valid) w_state_nxt = S_STROBE;
            end
            S_STROBE: begin
                wb_stb_o    = 1'b1;
                w_tmr_clear = 1'b1;
                w_state_nxt = wb_ack_i ? S_SEND_STATUS : S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                w_tmr_en = 1'b1;
                if (wb_ack_i || w_tmr_expired) w_state_nxt = S_SEND_STATUS;
            end
            S_SEND_STATUS: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    w_state_nxt = (!r_we && (r_status != ST_BADCMD)) ? S_SEND_DATA : S_IDLE;
                end
            end
            S_SEND_DATA: begin
                tx_valid = 1'b1;
                if (tx_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_adr    <= '0;
            r_wdat   <= '0;
            r_we     <= 1'b0;
            r_status <= ST_OK;
            r_rdata  <= '0;
        end else begin
            if ((r_state == S_IDLE) && rx_valid) begin
                if (cmd_is_bad(rx_data)) begin
                    r_status <= ST_BADCMD;
                end else begin
                    r_we  <= rx_data[CMD_WE_BIT];
                    r_adr <= rx_data[ADDR_W-1:0];
                end
            end
            if ((r_state == S_GET_DATA) && rx_valid) begin
                r_wdat <= DATA_W'(rx_data);
            end
            if (w_ack_ok) begin
                r_status <= ST_OK;
                if (!r_we) r_rdata <= 8'(wb_dat_i);
            end else if (w_expired_now) begin
                r_status <= ST_TIMEOUT;
                r_rdata  <= '0;
            end
        end
    end

    assign tx_data  = (r_state == S_SEND_DATA) ? r_rdata : r_status;
    assign wb_adr_o = r_adr;
    assign wb_dat_o = r_wdat;
    assign wb_we_o  = r_we;
    assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_wb_byte_master.sv
// tb/tb_wb_byte_master.sv - randomized scoreboard bench for wb_byte_master
module tb_wb_byte_master;
    localparam int TIMEOUT = 15;

    typedef struct {
        logic [3:0] adr;
        logic       we;
        logic [7:0] dat;
        int         dly;
    } op_t;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [3:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i = 8'h00;
    logic       wb_we_o;
    logic       wb_stb_o;
    logic       wb_ack_i = 1'b0;
    logic       busy;

    int         checks = 0;
    int         failures = 0;
    logic       hold = 1'b0;
    logic [7:0] exp_q[$];
    op_t        op_q[$];
    logic [7:0] model_mem[16];
    logic [7:0] slave_mem[16];
    int         ack_cnt = -1;
    logic       prev_stb = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    wb_byte_master #(.ADDR_W(4), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always begin
        @(posedge clk);
        #2;
        tx_ready = hold ? 1'b0 : ($urandom % 4 != 0);
    end

    // Wishbone slave: writes land on the strobe, ack after the per-op delay (-1 = never).
    always @(negedge clk) begin
        if (!rst_i) begin
            ack_cnt  = -1;
            wb_ack_i = 1'b0;
            prev_stb = 1'b0;
        end else begin
            wb_ack_i = 1'b0;
            if (ack_cnt >= 0) begin
                if (ack_cnt == 0) wb_ack_i = 1'b1;
                ack_cnt--;
            end
            if (wb_stb_o) begin
                op_t op;
                chk("stb_single_cycle", 32'(prev_stb), 32'd0);
                if (op_q.size() == 0) begin
                    chk("stb_unexpected", 32'd1, 32'd0);
                end else begin
                    op = op_q.pop_front();
                    chk("wb_adr", 32'(wb_adr_o), 32'(op.adr));
                    chk("wb_we", 32'(wb_we_o), 32'(op.we));
                    if (op.we) begin
                        chk("wb_dat", 32'(wb_dat_o), 32'(op.dat));
                        slave_mem[wb_adr_o] = wb_dat_o;
                    end
                    wb_dat_i = slave_mem[wb_adr_o];
                    if (op.dly == 0) wb_ack_i = 1'b1;
                    else if (op.dly > 0) ack_cnt = op.dly - 1;
                end
            end
            prev_stb = wb_stb_o;
        end
    end

    always @(negedge clk) begin
        if (!rst_i) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("tx_hold_valid", 32'(tx_valid), 32'd1);
                chk("tx_hold_data", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid) chk("rx_ready_during_resp", 32'(rx_ready), 32'd0);
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) chk("tx_unexpected", 32'd1, 32'd0);
                else chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    task automatic chk_reset();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_stb", 32'(wb_stb_o), 32'd0);
        chk("rst_we", 32'(wb_we_o), 32'd0);
        chk("rst_adr", 32'(wb_adr_o), 32'd0);
        chk("rst_dat", 32'(wb_dat_o), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) chk("rx_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic do_txn(input logic [2:0] rsv, input logic we, input logic [3:0] adr,
                          input logic [7:0] dat, input int dly);
        op_t op;
        bit  ok;
        if (rsv != 3'b000) begin
            exp_q.push_back(8'h02);
            send_byte({we, rsv, adr});
            return;
        end
        ok = (dly >= 0) && (dly <= TIMEOUT);
        op.adr = adr; op.we = we; op.dat = dat; op.dly = dly;
        op_q.push_back(op);
        if (we) model_mem[adr] = dat;
        exp_q.push_back(ok ? 8'h00 : 8'h01);
        if (!we) exp_q.push_back(ok ? model_mem[adr] : 8'h00);
        send_byte({we, 3'b000, adr});
        if (we) send_byte(dat);
    endtask

    task automatic measure(input string name, input int exp_k);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!tx_valid && k < 100);
        chk(name, 32'(k), 32'(exp_k));
    endtask

    initial begin
        int n;
        int r;
        int dly;
        for (int i = 0; i < 16; i++) begin
            slave_mem[i] = 8'($urandom);
            model_mem[i] = slave_mem[i];
        end
        repeat (3) @(posedge clk);
        #1;
        chk_reset();
        rst_i = 1'b1;
        @(posedge clk);
        #1;

        do_txn(3'b000, 1'b1, 4'h1, 8'h2A, 1);
        measure("lat_write", 3);
        do_txn(3'b000, 1'b0, 4'h1, 8'h00, 1);
        measure("lat_read", 3);
        do_txn(3'b000, 1'b0, 4'h3, 8'h00, -1);
        measure("lat_timeout", TIMEOUT + 2);
        do_txn(3'b000, 1'b1, 4'h7, 8'h5C, TIMEOUT);
        do_txn(3'b000, 1'b0, 4'h7, 8'h00, TIMEOUT);
        do_txn(3'b000, 1'b0, 4'h7, 8'h00, TIMEOUT + 1);
        do_txn(3'b000, 1'b0, 4'h2, 8'h00, 0);
        do_txn(3'b001, 1'b1, 4'h0, 8'h00, 0);
        do_txn(3'b000, 1'b0, 4'h1, 8'h00, 2);

        while (busy) @(posedge clk);
        #1;
        hold = 1'b1;
        do_txn(3'b000, 1'b0, 4'h1, 8'h00, 1);
        repeat (2) @(negedge clk);
        repeat (20) begin
            @(negedge clk);
            chk("bp_tx_valid", 32'(tx_valid), 32'd1);
            chk("bp_tx_data", 32'(tx_data), 32'h00);
            chk("bp_rx_ready", 32'(rx_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        hold = 1'b0;

        while (busy) @(posedge clk);
        #1;
        send_byte(8'h85);
        chk("mid_busy", 32'(busy), 32'd1);
        rst_i = 1'b0;
        #1;
        chk_reset();
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        do_txn(3'b000, 1'b0, 4'h0, 8'h00, 1);

        for (int i = 0; i < 60; i++) begin
            r = $urandom % 10;
            if (r < 7)       dly = $urandom_range(0, 3);
            else if (r == 7) dly = TIMEOUT - int'($urandom % 2);
            else if (r == 8) dly = -1;
            else             dly = TIMEOUT + 1;
            do_txn(($urandom % 8 == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
                   1'($urandom), 4'($urandom), 8'($urandom), dly);
        end

        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_tx", 32'(exp_q.size()), 32'd0);
        chk("drain_wb", 32'(op_q.size()), 32'd0);
        chk("final_busy", 32'(busy), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
